// File: rtl/rme_insert_pkg.sv
// rme_insert_pkg
//   Shared types for the BRAM-write insert stage: the FIFO entry layout,
//   the drain state machine encoding and the strobe width.
//   No ports (package).
package rme_insert_pkg;

    localparam int ENTRY_ADDR_W = 14;
    localparam int ENTRY_DATA_W = 128;
    localparam int STRB_W       = ENTRY_DATA_W / 8;

    // 'last' is declared last so it lands on bit 0 of the packed entry;
    // the FIFO's newest-entry marking relies on that position.
    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_DATA_W-1:0] data;
        logic [STRB_W-1:0]       strb;
        logic                    last;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        NOTIFY = 2'd2
    } drain_state_t;

endpackage

// File: rtl/rme_sync_fifo.sv
// rme_sync_fifo
//   Single-clock register FIFO with an asynchronous active-low reset on its
//   control state. Head entry is presented combinationally on o_rdata.
//   Ports:
//     clk, rst_n       clock, async active-low reset
//     i_push, i_wdata  write request and entry (ignored when full without pop)
//     i_pop            consume head (ignored when empty)
//     i_mark_newest    OR bit 0 of the most recently written entry
//     o_rdata          head entry
//     o_full, o_empty  occupancy flags
//     o_level          number of stored entries (0..DEPTH)
module rme_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    input  logic                   i_mark_newest,
    output logic [W-1:0]           o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_newest;

    assign o_full    = (r_level == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being written is the head being popped this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_newest  = r_wr_ptr - PTR_W'(1);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end else if (i_mark_newest && !o_empty) begin
            r_mem[w_newest][0] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (PTR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/rme_insert_stage.sv
// rme_insert_stage
//   Stages the front end's per-beat BRAM writes in a FIFO and drains them
//   into the cache memory port over valid/ready. Pulses data_inserted the
//   cycle after the final beat of a burst is accepted.
//   ADDR_W/DATA_W must match the entry layout in rme_insert_pkg.
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESETN    clock, async active-low reset
//     in_en/in_addr/in_data/in_we  beat from the front end (present: en && |we)
//     in_last, in_size             burst end marker, burst beats minus one
//     mem_valid/addr/wdata/wstrb   cache write request (held until mem_ready)
//     mem_ready                    cache accepts request
//     data_inserted                one-cycle burst-complete pulse
//     fifo_level                   stored entries (output register excluded)
//     overflow_err, len_err        sticky error flags
module rme_insert_stage
    import rme_insert_pkg::*;
#(
    parameter int ADDR_W = ENTRY_ADDR_W,
    parameter int DATA_W = ENTRY_DATA_W,
    parameter int DEPTH  = 32
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    input  logic                     in_en,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [DATA_W/8-1:0]      in_we,
    input  logic                     in_last,
    input  logic [7:0]               in_size,
    output logic                     mem_valid,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W/8-1:0]      mem_wstrb,
    input  logic                     mem_ready,
    output logic                     data_inserted,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow_err,
    output logic                     len_err
);

    drain_state_t       r_state;
    drain_state_t       w_state_nxt;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W/8-1:0] r_mem_wstrb;
    logic                r_cur_last;
    logic [7:0]          r_beat_cnt;
    logic                r_len_err;
    logic                r_ovf_err;

    logic                w_present;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_load;
    logic                w_push;
    logic                w_drop;
    logic                w_mark;
    fifo_entry_t         w_wr_entry;
    fifo_entry_t         w_head;

    assign w_present  = in_en && (|in_we);
    // A pop in the same cycle frees a slot, so only push-without-pop on a
    // full FIFO loses a beat.
    assign w_push     = w_present && (!w_full || w_pop);
    assign w_drop     = w_present && w_full && !w_pop;
    // A dropped final beat hands its last marker to the newest stored entry
    // so the burst still terminates exactly once.
    assign w_mark     = w_drop && in_last;
    assign w_wr_entry = '{addr: in_addr, data: in_data, strb: in_we, last: in_last};

    rme_sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (S_AXI_ACLK),
        .rst_n         (S_AXI_ARESETN),
        .i_push        (w_push),
        .i_wdata       (w_wr_entry),
        .i_pop         (w_pop),
        .i_mark_newest (w_mark),
        .o_rdata       (w_head),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_level       (fifo_level)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (mem_ready) begin
                    if (r_cur_last) begin
                        w_state_nxt = NOTIFY;
                    end else if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            NOTIFY:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_cur_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_mem_addr  <= w_head.addr;
                r_mem_wdata <= w_head.data;
                r_mem_wstrb <= w_head.strb;
                r_cur_last  <= w_head.last;
            end
        end
    end

    // Dropped beats still count, so a burst's length check is unaffected
    // by overflow.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else begin
            if (w_present) begin
                if (in_last) begin
                    r_beat_cnt <= '0;
                    if (r_beat_cnt != in_size) r_len_err <= 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                end
            end
            if (w_drop) r_ovf_err <= 1'b1;
        end
    end

    assign mem_valid     = (r_state == SEND);
    assign data_inserted = (r_state == NOTIFY);
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wstrb     = r_mem_wstrb;
    assign overflow_err  = r_ovf_err;
    assign len_err       = r_len_err;

endmodule

// File: tb/tb_rme_insert_stage.sv
module tb_rme_insert_stage;

    localparam int AW    = 14;
    localparam int DW    = 128;
    localparam int SW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_en;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_we;
    logic          in_last;
    logic [7:0]    in_size;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_ready;
    logic          data_inserted;
    logic [2:0]    fifo_level;
    logic          overflow_err;
    logic          len_err;

    rme_insert_stage #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .in_en         (in_en),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_we         (in_we),
        .in_last       (in_last),
        .in_size       (in_size),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .data_inserted (data_inserted),
        .fifo_level    (fifo_level),
        .overflow_err  (overflow_err),
        .len_err       (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } exp_t;

    typedef struct {
        logic [AW-1:0] base;
        int            nbeats;
        logic [7:0]    size;
        int            last_at;
        int            stall_at;
        int            stall_len;
        bit            gap;
        logic [SW-1:0] strb;
        logic          exp_len_err;
        int            exp_pulses;
    } vec_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Configuration read by the monitor.
    bit   mon_en = 1'b0;
    logic ready_default = 1'b1;
    int   stall_at = -1;
    int   stall_len = 0;

    // Monitor-owned state.
    int            stall_rem;
    int            hs_cnt;
    int            pulse_cnt;
    int            cyc = 0;
    int            last_pulse_cyc;
    bit            exp_pulse;
    bit            prev_stalled;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_strb;
    exp_t          mon_e;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            exp_pulse    = 1'b0;
            prev_stalled = 1'b0;
            hs_cnt       = 0;
            pulse_cnt    = 0;
            stall_rem    = stall_len;
            mem_ready    = ready_default;
        end else begin
            if (exp_pulse || data_inserted) begin
                check("data_inserted", data_inserted, exp_pulse);
                if (data_inserted) begin
                    check("valid_during_pulse", mem_valid, 1'b0);
                    if (pulse_cnt > 0) begin
                        tests++;
                        if (cyc - last_pulse_cyc < 3) begin
                            fails++;
                            $display("FAIL pulse_gap: got %0d cycles, required >= 3", cyc - last_pulse_cyc);
                        end
                    end
                    pulse_cnt++;
                    last_pulse_cyc = cyc;
                end
            end
            exp_pulse = 1'b0;
            if (prev_stalled) begin
                check("stall_valid", mem_valid, 1'b1);
                check("stall_addr", mem_addr, prev_addr);
                check("stall_data", mem_wdata, prev_data);
                check("stall_strb", mem_wstrb, prev_strb);
            end
            if (mem_valid && hs_cnt == stall_at && stall_rem > 0) begin
                mem_ready = 1'b0;
                stall_rem--;
            end else begin
                mem_ready = ready_default;
            end
            prev_stalled = mem_valid && !mem_ready;
            prev_addr    = mem_addr;
            prev_data    = mem_wdata;
            prev_strb    = mem_wstrb;
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got addr %0h, required no request", mem_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("req_addr", mem_addr, mon_e.addr);
                    check("req_data", mem_wdata, mon_e.data);
                    check("req_strb", mem_wstrb, mon_e.strb);
                    exp_pulse = mon_e.last;
                end
                hs_cnt++;
            end
        end
    end

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        in_en  = 1'b0;
        in_we  = '0;
        in_last = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Drives nbeats beats; the first 'keep' become expected requests, and a
    // final marker on a lost beat moves to the last kept one.
    task automatic drive_burst(input logic [AW-1:0] base, input int nbeats, input logic [7:0] size,
                               input int last_at, input logic [SW-1:0] strb, input bit gap, input int keep);
        exp_t e;
        in_size = size;
        for (int i = 0; i < nbeats; i++) begin
            if (gap && i == 1) begin
                in_en   = 1'b1;
                in_we   = '0;
                in_last = 1'b1;
                in_data = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk);
                #1;
            end
            in_en   = 1'b1;
            in_addr = base + AW'(i * 16);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_we   = strb;
            in_last = (i == last_at);
            if (i < keep) begin
                e.addr = in_addr;
                e.data = in_data;
                e.strb = strb;
                e.last = (i == last_at) || (i == keep - 1 && last_at >= keep);
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_en   = 1'b0;
        in_we   = '0;
        in_last = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mem_valid || data_inserted) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending, required 0 within %0d cycles", exp_q.size(), budget);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{14'h0100, 4, 8'd3, 3, -1, 0, 1'b0, 16'hFFFF, 1'b0, 1};
        vecs[1] = '{14'h0100, 4, 8'd3, 3,  1, 5, 1'b0, 16'hFFFF, 1'b0, 1};
        vecs[2] = '{14'h0200, 3, 8'd5, 2, -1, 0, 1'b0, 16'hFFFF, 1'b1, 1};
        vecs[3] = '{14'h3FE0, 3, 8'd2, 2, -1, 0, 1'b1, 16'h00F0, 1'b0, 1};
        vecs[4] = '{14'h0040, 1, 8'd0, 0,  2, 3, 1'b0, 16'h8001, 1'b0, 1};

        rst_n = 1'b0; in_en = 1'b0; in_addr = '0; in_data = '0;
        in_we = '0; in_last = 1'b0; in_size = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_data_inserted", data_inserted, 1'b0);
        check("rst_overflow", overflow_err, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_mem_wstrb", mem_wstrb, '0);

        foreach (vecs[v]) begin
            stall_at  = vecs[v].stall_at;
            stall_len = vecs[v].stall_len;
            ready_default = 1'b1;
            do_reset();
            drive_burst(vecs[v].base, vecs[v].nbeats, vecs[v].size, vecs[v].last_at,
                        vecs[v].strb, vecs[v].gap, vecs[v].nbeats);
            wait_drain(200);
            check($sformatf("v%0d_len_err", v), len_err, vecs[v].exp_len_err);
            check($sformatf("v%0d_overflow", v), overflow_err, 1'b0);
            check($sformatf("v%0d_pulses", v), pulse_cnt, vecs[v].exp_pulses);
            check($sformatf("v%0d_level", v), fifo_level, 3'd0);
        end

        // Overflow: nothing drains while 8 beats arrive into 4 slots plus
        // the output register; beats 5..7 are lost, last merges onto beat 4.
        stall_at = -1; stall_len = 0;
        ready_default = 1'b0;
        do_reset();
        drive_burst(14'h0500, 8, 8'd7, 7, 16'hFFFF, 1'b0, 5);
        check("ovf_flag", overflow_err, 1'b1);
        check("ovf_level", fifo_level, 3'd4);
        check("ovf_head_valid", mem_valid, 1'b1);
        check("ovf_head_addr", mem_addr, 14'h0500);
        check("ovf_len_err", len_err, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("ovf_level_hold", fifo_level, 3'd4);
        end
        ready_default = 1'b1;
        wait_drain(200);
        check("ovf_pulses", pulse_cnt, 1);
        check("ovf_sticky", overflow_err, 1'b1);
        check("ovf_level_end", fifo_level, 3'd0);

        // Two back-to-back 2-beat bursts.
        do_reset();
        drive_burst(14'h0600, 2, 8'd1, 1, 16'hFFFF, 1'b0, 2);
        drive_burst(14'h0700, 2, 8'd1, 1, 16'h0F0F, 1'b0, 2);
        wait_drain(200);
        check("b2b_pulses", pulse_cnt, 2);
        check("b2b_len_err", len_err, 1'b0);

        // Asynchronous reset in the middle of a stalled, overflowed drain.
        ready_default = 1'b0;
        do_reset();
        drive_burst(14'h0800, 8, 8'd7, 7, 16'hFFFF, 1'b0, 0);
        check("pre_rst_valid", mem_valid, 1'b1);
        check("pre_rst_ovf", overflow_err, 1'b1);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_valid", mem_valid, 1'b0);
        check("async_rst_level", fifo_level, 3'd0);
        check("async_rst_ovf", overflow_err, 1'b0);
        check("async_rst_len", len_err, 1'b0);
        check("async_rst_pulse", data_inserted, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_pulse", data_inserted, 1'b0);
        end
        @(posedge clk);
        #1;
        ready_default = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        drive_burst(14'h0100, 4, 8'd3, 3, 16'hFFFF, 1'b0, 4);
        wait_drain(200);
        check("post_rst_pulses", pulse_cnt, 1);
        check("post_rst_len_err", len_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required finish before 300000");
        $fatal(1, "watchdog");
    end

endmodule
